seq_pattern_checker: RTL and testbench

Serial test-pattern checker sitting directly downstream of the sequence generator in the encode test path. It consumes the generator's 1-bit data/valid stream and aligns to the repeating pattern ("101" or "1010") without knowing its starting phase. After alignment it checks every bit and reports lock status, a per-bit error strobe and saturating bit/error counters for link BER measurement.

---
 rtl/seq_pattern_checker_pkg.sv | 22 ++
 rtl/seq_pattern_checker_expect.sv | 29 ++
 rtl/seq_pattern_checker.sv | 126 ++++++++++++
 tb/tb_seq_pattern_checker.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pattern_checker_pkg.sv
// Shared definitions for the serial test-pattern checker: FSM states, pattern
// periods and the expected-bit table that the upstream generator must mirror.
package seq_pattern_checker_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int PERIOD_3 = 3;
  localparam int PERIOD_4 = 4;

  // pattern 0 = "101" (period 3), pattern 1 = "1010" (period 4)
  function automatic logic pattern_bit(input logic pattern, input logic [1:0] phase);
    logic b;
    if (!pattern) b = (phase != 2'd1);
    else          b = ~phase[0];
    return b;
  endfunction

endpackage

// File: rtl/seq_pattern_checker_expect.sv
// Phase counter for the repeating test pattern; yields the bit expected next.
module seq_expect
  import seq_pattern_checker_pkg::*;
#(
  parameter int PATTERN = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic seed,
  input  logic advance,
  output logic exp_bit
);

  localparam int         PERIOD = (PATTERN != 0) ? PERIOD_4 : PERIOD_3;
  localparam logic [1:0] LAST   = 2'(PERIOD - 1);

  // Holds the index of the next expected bit: a seed bit sits at index 0,
  // so seeding loads index 1.
  logic [1:0] phase_q;

  always_ff @(posedge clk) begin
    if (rst)          phase_q <= 2'd0;
    else if (seed)    phase_q <= 2'd1;
    else if (advance) phase_q <= (phase_q == LAST) ? 2'd0 : phase_q + 2'd1;
  end

  assign exp_bit = pattern_bit(PATTERN != 0, phase_q);

endmodule

// File: rtl/seq_pattern_checker.sv
// Serial pattern checker: hunts for phase, verifies alignment, then counts
// checked and erroneous bits with saturating counters while locked.
module seq_pattern_checker
  import seq_pattern_checker_pkg::*;
#(
  parameter int PATTERN  = 0,
  parameter int LOCK_CNT = 8,
  parameter int LOSS_CNT = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] chk_cnt
);

  localparam int                 MATCH_W   = $clog2(LOCK_CNT + 1);
  localparam int                 MISS_W    = $clog2(LOSS_CNT + 1);
  localparam logic [MATCH_W-1:0] LOCK_LAST = MATCH_W'(LOCK_CNT - 1);
  localparam logic [MISS_W-1:0]  LOSS_LAST = MISS_W'(LOSS_CNT - 1);

  state_t             state_q, state_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [MISS_W-1:0]  miss_q, miss_d;
  logic               vld_p1;
  logic               seed, advance, exp_bit, hit;
  logic               pulse_d, bump;
  logic [CNT_W-1:0]   err_d, chk_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    return (inc && !(&v)) ? v + CNT_W'(1) : v;
  endfunction

  seq_expect #(.PATTERN(PATTERN)) u_expect (
    .clk     (clk),
    .rst     (rst),
    .seed    (seed),
    .advance (advance),
    .exp_bit (exp_bit)
  );

  assign hit = (din == exp_bit);

  always_comb begin
    state_d = state_q;
    match_d = match_q;
    miss_d  = miss_q;
    seed    = 1'b0;
    advance = 1'b0;
    pulse_d = 1'b0;
    bump    = 1'b0;
    // The generator restarts at index 0 after a pause, so alignment is void.
    if (!din_valid && vld_p1) begin
      state_d = HUNT;
      match_d = '0;
      miss_d  = '0;
    end else if (din_valid) begin
      unique case (state_q)
        HUNT: begin
          if (din) begin
            seed    = 1'b1;
            match_d = MATCH_W'(1);
            state_d = VERIFY;
          end
        end
        VERIFY: begin
          if (hit) begin
            advance = 1'b1;
            match_d = match_q + 1'b1;
            if (match_q == LOCK_LAST) begin
              state_d = LOCKED;
              miss_d  = '0;
            end
          end else if (din) begin
            seed    = 1'b1;
            match_d = MATCH_W'(1);
          end else begin
            state_d = HUNT;
          end
        end
        LOCKED: begin
          advance = 1'b1;
          bump    = 1'b1;
          if (!hit) begin
            pulse_d = 1'b1;
            miss_d  = miss_q + 1'b1;
            if (miss_q == LOSS_LAST) state_d = HUNT;
          end else begin
            miss_d = '0;
          end
        end
        default: state_d = HUNT;
      endcase
    end
    err_d = clr ? '0 : sat_inc(err_cnt, pulse_d);
    chk_d = clr ? '0 : sat_inc(chk_cnt, bump);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= HUNT;
      match_q   <= '0;
      miss_q    <= '0;
      vld_p1    <= 1'b0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
      chk_cnt   <= '0;
    end else begin
      state_q   <= state_d;
      match_q   <= match_d;
      miss_q    <= miss_d;
      vld_p1    <= din_valid;
      err_pulse <= pulse_d;
      err_cnt   <= err_d;
      chk_cnt   <= chk_d;
    end
  end

  assign locked = (state_q == LOCKED);

endmodule

// File: tb/tb_seq_pattern_checker.sv
// Bench for seq_pattern_checker: a period-3 instance (16-bit counters) and a
// period-4 instance (4-bit counters) share stimulus and are checked each cycle.
module tb_seq_pattern_checker;

  logic        clk = 1'b0;
  logic        rst, din, din_valid, clr;
  logic        locked0, pulse0, locked1, pulse1;
  logic [15:0] err0, chk0;
  logic [3:0]  err1, chk1;

  int compared   = 0;
  int mismatched = 0;

  localparam int LOCK_N = 8;
  localparam int LOSS_N = 4;

  always #5 clk = ~clk;

  seq_pattern_checker #(.PATTERN(0), .LOCK_CNT(8), .LOSS_CNT(4), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr(clr),
    .locked(locked0), .err_pulse(pulse0), .err_cnt(err0), .chk_cnt(chk0)
  );

  seq_pattern_checker #(.PATTERN(1), .LOCK_CNT(8), .LOSS_CNT(4), .CNT_W(4)) u1 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr(clr),
    .locked(locked1), .err_pulse(pulse1), .err_cnt(err1), .chk_cnt(chk1)
  );

  // Reference: mode 0 hunting, 1 verifying, 2 locked; ph is next expected index.
  int m_mode[2], m_ph[2], m_mc[2], m_xc[2], m_err[2], m_chk[2], m_pulse[2], m_prev[2];

  function automatic int pat(input int p, input int i);
    if (p == 0) return (i % 3 == 1) ? 0 : 1;
    return (i % 2 == 0) ? 1 : 0;
  endfunction

  task automatic model_step(input int k, input int per, input int maxv,
                            input logic r, input logic d, input logic v, input logic c);
    int   e_inc = 0;
    int   c_inc = 0;
    logic exp_b;
    if (r) begin
      m_mode[k] = 0; m_ph[k] = 0; m_mc[k] = 0; m_xc[k] = 0;
      m_err[k] = 0; m_chk[k] = 0; m_pulse[k] = 0; m_prev[k] = 0;
      return;
    end
    m_pulse[k] = 0;
    if (!v && m_prev[k] != 0) begin
      m_mode[k] = 0; m_mc[k] = 0; m_xc[k] = 0;
    end else if (v) begin
      if (m_mode[k] == 0) begin
        if (d) begin m_ph[k] = 1; m_mc[k] = 1; m_mode[k] = 1; end
      end else begin
        exp_b = (pat(k, m_ph[k]) != 0);
        if (m_mode[k] == 1) begin
          if (d == exp_b) begin
            m_ph[k] = (m_ph[k] + 1) % per;
            m_mc[k]++;
            if (m_mc[k] == LOCK_N) begin m_mode[k] = 2; m_xc[k] = 0; end
          end else if (d) begin
            m_ph[k] = 1; m_mc[k] = 1;
          end else begin
            m_mode[k] = 0;
          end
        end else begin
          m_ph[k] = (m_ph[k] + 1) % per;
          c_inc = 1;
          if (d != exp_b) begin
            m_pulse[k] = 1; e_inc = 1; m_xc[k]++;
            if (m_xc[k] == LOSS_N) m_mode[k] = 0;
          end else begin
            m_xc[k] = 0;
          end
        end
      end
    end
    m_err[k]  = c ? 0 : ((m_err[k] + e_inc > maxv) ? maxv : m_err[k] + e_inc);
    m_chk[k]  = c ? 0 : ((m_chk[k] + c_inc > maxv) ? maxv : m_chk[k] + c_inc);
    m_prev[k] = v;
  endtask

  task automatic ck(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    ck("u0.locked",    32'(locked0), 32'(m_mode[0] == 2));
    ck("u0.err_pulse", 32'(pulse0),  32'(m_pulse[0]));
    ck("u0.err_cnt",   32'(err0),    32'(m_err[0]));
    ck("u0.chk_cnt",   32'(chk0),    32'(m_chk[0]));
    ck("u1.locked",    32'(locked1), 32'(m_mode[1] == 2));
    ck("u1.err_pulse", 32'(pulse1),  32'(m_pulse[1]));
    ck("u1.err_cnt",   32'(err1),    32'(m_err[1]));
    ck("u1.chk_cnt",   32'(chk1),    32'(m_chk[1]));
  endtask

  task automatic tick(input logic r, input logic d, input logic v, input logic c);
    rst = r; din = d; din_valid = v; clr = c;
    @(posedge clk);
    model_step(0, 3, 65535, r, d, v, c);
    model_step(1, 4, 15, r, d, v, c);
    #1;
    check_all();
  endtask

  task automatic send(input logic d);
    tick(1'b0, d, 1'b1, 1'b0);
  endtask

  initial begin
    int   j;
    int   sel;
    logic r, v, c, d;

    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    ck("reset.locked", 32'(locked0), 0);
    ck("reset.err_cnt", 32'(err0), 0);

    // Period-3 stream from index 0: lock after bit 8, then count.
    for (int i = 0; i < 20; i++) begin
      send(pat(0, i) != 0);
      if (i == 6) ck("lock.before", 32'(locked0), 0);
      if (i == 7) ck("lock.after", 32'(locked0), 1);
    end
    ck("clean.err_cnt", 32'(err0), 0);
    ck("clean.chk_cnt", 32'(chk0), 12);

    // Four consecutive inverted bits drop lock.
    for (int i = 20; i < 24; i++) begin
      send(pat(0, i) == 0);
      ck("loss.pulse", 32'(pulse0), 1);
      if (i < 23) ck("loss.still_locked", 32'(locked0), 1);
    end
    ck("loss.locked", 32'(locked0), 0);
    ck("loss.err_cnt", 32'(err0), 4);
    ck("loss.chk_cnt", 32'(chk0), 16);

    for (int i = 24; i < 36; i++) begin
      send(pat(0, i) != 0);
      if (i == 30) ck("relock.before", 32'(locked0), 0);
      if (i == 31) ck("relock.after", 32'(locked0), 1);
    end

    // Valid gap while locked: lock drops, statistics are kept.
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    ck("gap.locked", 32'(locked0), 0);
    ck("gap.err_cnt", 32'(err0), 4);
    ck("gap.chk_cnt", 32'(chk0), 20);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);

    for (j = 0; j < 10; j++) send(pat(0, j) != 0);
    ck("gap.relock", 32'(locked0), 1);
    tick(1'b0, pat(0, j) == 0, 1'b1, 1'b1);
    j++;
    ck("clr.pulse", 32'(pulse0), 1);
    ck("clr.err_cnt", 32'(err0), 0);
    ck("clr.chk_cnt", 32'(chk0), 0);

    for (int k = 0; k < 5; k++) begin
      send(pat(0, j) == 0); j++;
      send(pat(0, j) != 0); j++;
      send(pat(0, j) != 0); j++;
    end
    ck("five.err_cnt", 32'(err0), 5);
    ck("five.locked", 32'(locked0), 1);
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    ck("rst.locked", 32'(locked0), 0);
    ck("rst.pulse", 32'(pulse0), 0);
    ck("rst.err_cnt", 32'(err0), 0);
    ck("rst.chk_cnt", 32'(chk0), 0);

    // Period-3 stream entered at index 2: reseed on the second 1.
    for (int i = 0; i < 12; i++) begin
      send(pat(0, i + 2) != 0);
      if (i == 7) ck("idx2.before", 32'(locked0), 0);
      if (i == 8) ck("idx2.after", 32'(locked0), 1);
    end

    // Period-4 instance: single error, then saturation of 4-bit counters.
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    for (j = 0; j < 12; j++) begin
      send(pat(1, j) != 0);
      if (j == 7) ck("p4.lock", 32'(locked1), 1);
    end
    send(pat(1, j) == 0); j++;
    ck("p4.pulse", 32'(pulse1), 1);
    ck("p4.err_cnt", 32'(err1), 1);
    ck("p4.locked", 32'(locked1), 1);
    send(pat(1, j) != 0); j++;
    ck("p4.pulse_one_cycle", 32'(pulse1), 0);
    for (int k = 0; k < 20; k++) begin
      send(pat(1, j) == 0); j++;
      send(pat(1, j) != 0); j++;
    end
    ck("sat.err_cnt", 32'(err1), 15);
    ck("sat.chk_cnt", 32'(chk1), 15);
    ck("sat.locked", 32'(locked1), 1);

    // Randomized traffic alternating between the two patterns.
    j = 0;
    for (int n = 0; n < 600; n++) begin
      sel = (n / 150) % 2;
      r = ($urandom_range(0, 149) == 0);
      v = ($urandom_range(0, 7) != 0);
      c = ($urandom_range(0, 59) == 0);
      if (v) begin
        d = (pat(sel, j) != 0) ^ ($urandom_range(0, 11) == 0);
        j++;
      end else begin
        d = 1'($urandom);
        j = 0;
      end
      if (r) j = 0;
      tick(r, d, v, c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
